// File: rtl/profrom_plane_seq.sv
// rtl/profrom_plane_seq.sv - host-side initiator for the ProfROM plane-switch knock protocol
//
// Generates the read "knocks" (a[15:4]=12'h810, a[3:2]=transition offset) that the
// ROM-side switcher decodes, keeping a shadow of the ROM plane. The new plane commits
// on the oe_n rising edge, which is when the shadow is updated here too.
//
// Ports:
//   fclk        system clock
//   rst         asynchronous active-high reset
//   req         start request, sampled only in IDLE
//   target      requested plane, latched with req
//   resync      force a blind resync, latched with req
//   invalidate  another master touched the ROM window; clears plane_valid
//   busy        high from the accepted req until the DONE state is left
//   done        one-clock completion pulse
//   plane       shadow of the current ROM plane
//   plane_valid shadow is trustworthy
//   bus_req     bus request to the arbiter
//   bus_gnt     bus grant
//   a           bus address
//   oe_n        read strobe, active low
module profrom_plane_seq #(
  parameter int SETUP_CLKS  = 2,
  parameter int STROBE_CLKS = 3,
  parameter int HOLD_CLKS   = 1
) (
  input  logic        fclk,
  input  logic        rst,
  input  logic        req,
  input  logic [1:0]  target,
  input  logic        resync,
  input  logic        invalidate,
  output logic        busy,
  output logic        done,
  output logic [1:0]  plane,
  output logic        plane_valid,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [15:0] a,
  output logic        oe_n
);

  typedef enum logic [2:0] {IDLE, ARB, SETUP, STROBE, HOLD, NEXT, DONE} state_t;

  localparam logic [3:0] SETUP_LOAD  = 4'(SETUP_CLKS - 1);
  localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CLKS - 1);
  localparam logic [3:0] HOLD_LOAD   = 4'(HOLD_CLKS - 1);

  // Resync progress: none, first knock (offset 3) in flight, second knock (offset 1) in flight
  localparam logic [1:0] RS_NONE = 2'd0;
  localparam logic [1:0] RS_K1   = 2'd1;
  localparam logic [1:0] RS_K2   = 2'd2;

  state_t     state;
  logic [3:0] cnt;
  logic [1:0] tgt;
  logic [1:0] off;
  logic [1:0] rs_stage;
  logic       eff_resync;

  // Plane reached by the switcher after a knock at offset o from plane p
  function automatic logic [1:0] map_plane(input logic [1:0] o, input logic [1:0] p);
    logic [1:0] r;
    case (o)
      2'd0:    r = p;
      2'd1:    r = (p == 2'd3) ? 2'd2 : 2'd3;
      2'd2:    case (p)
                 2'd0, 2'd1: r = 2'd2;
                 2'd2:       r = 2'd0;
                 default:    r = 2'd1;
               endcase
      default: r = {1'b0, ~p[0]};
    endcase
    return r;
  endfunction

  // The unique non-zero offset taking plane p to t (the map is built so one always exists)
  function automatic logic [1:0] offset_for(input logic [1:0] p, input logic [1:0] t);
    logic [1:0] o;
    o = 2'd0;
    for (int i = 1; i < 4; i++) begin
      if (map_plane(2'(i), p) == t) o = 2'(i);
    end
    return o;
  endfunction

  function automatic logic [15:0] knock_addr(input logic [1:0] o);
    return {12'h810, o, 2'b00};
  endfunction

  assign eff_resync = resync | ~plane_valid;

  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      tgt         <= 2'd0;
      off         <= 2'd0;
      rs_stage    <= RS_NONE;
      busy        <= 1'b0;
      done        <= 1'b0;
      plane       <= 2'd0;
      plane_valid <= 1'b1;
      bus_req     <= 1'b0;
      a           <= 16'h0000;
      oe_n        <= 1'b1;
    end else begin
      done <= 1'b0;
      // A later assignment in the resync-completing HOLD entry overrides this
      if (invalidate) plane_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (req) begin
            tgt  <= target;
            busy <= 1'b1;
            if (!eff_resync && target == plane) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state   <= ARB;
              bus_req <= 1'b1;
              if (eff_resync) begin
                rs_stage <= RS_K1;
                off      <= 2'd3;
              end else begin
                rs_stage <= RS_NONE;
                off      <= offset_for(plane, target);
              end
            end
          end
        end

        ARB: begin
          if (bus_gnt) begin
            state <= SETUP;
            a     <= knock_addr(off);
            cnt   <= SETUP_LOAD;
          end
        end

        SETUP: begin
          if (cnt == 4'd0) begin
            state <= STROBE;
            oe_n  <= 1'b0;
            cnt   <= STROBE_LOAD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        STROBE: begin
          if (cnt == 4'd0) begin
            state <= HOLD;
            oe_n  <= 1'b1;
            cnt   <= HOLD_LOAD;
            // The switcher commits on this oe_n rising edge, so the shadow follows now
            if (rs_stage == RS_K2) begin
              plane       <= 2'd3;
              plane_valid <= 1'b1;
            end else begin
              plane <= map_plane(off, plane);
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        HOLD: begin
          if (cnt == 4'd0) state <= NEXT;
          else             cnt   <= cnt - 4'd1;
        end

        NEXT: begin
          if (rs_stage == RS_K1) begin
            rs_stage <= RS_K2;
            off      <= 2'd1;
            a        <= knock_addr(2'd1);
            cnt      <= SETUP_LOAD;
            state    <= SETUP;
          end else if (plane != tgt) begin
            // Only reachable after a resync that landed on 3 with another target
            rs_stage <= RS_NONE;
            off      <= offset_for(plane, tgt);
            a        <= knock_addr(offset_for(plane, tgt));
            cnt      <= SETUP_LOAD;
            state    <= SETUP;
          end else begin
            rs_stage <= RS_NONE;
            bus_req  <= 1'b0;
            a        <= 16'h0000;
            done     <= 1'b1;
            state    <= DONE;
          end
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
